falu_issue_ctrl: RTL and testbench

Issue controller for the single floating-point ALU (FAlu). Two requesters, the FP issue lanes 0 and 1, compete for the FAlu. The block grants them round-robin and tracks in-flight operations through a fixed-latency shadow pipeline to generate writeback valid/tag. It also serialises FCSR0-modifying instructions: the pipe drains before such an instruction issues, and it retires before anything else issues.

---
 rtl/falu_issue_ctrl_pkg.sv | 13 +
 rtl/falu_shadow_pipe.sv | 47 ++++
 rtl/falu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_falu_issue_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/falu_issue_ctrl_pkg.sv
// Shared definitions for the FAlu issue controller: field widths, latency default
// and FSM state encodings.
package falu_issue_ctrl_pkg;

    localparam int MIC_OP_W     = 8;   // `MicOperateCode width
    localparam int ARCH_REG_W   = 5;   // `ArchRegBUs width
    localparam int FALU_LATENCY = 3;

    localparam logic [1:0] FIC_IDLE   = 2'd0;
    localparam logic [1:0] FIC_DRAIN  = 2'd1;
    localparam logic [1:0] FIC_SERIAL = 2'd2;

endpackage

// File: rtl/falu_shadow_pipe.sv
// Fixed-latency shadow of the FAlu pipeline carrying {valid, tag, serial} per stage;
// flush drops all valids while tags/serial bits simply keep shifting.
module falu_shadow_pipe #(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ld_valid,
    input  logic             ld_serial,
    input  logic [TAG_W-1:0] ld_tag,
    output logic             any_valid,
    output logic             out_valid,
    output logic             out_serial,
    output logic [TAG_W-1:0] out_tag
);

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] ser;
    logic [TAG_W-1:0]   tag [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            ser <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag[i] <= '0;
            end
        end else begin
            vld[0] <= ld_valid & ~flush;
            ser[0] <= ld_serial;
            tag[0] <= ld_tag;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1] & ~flush;
                ser[i] <= ser[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign any_valid  = |vld;
    assign out_valid  = vld[LATENCY-1];
    assign out_serial = ser[LATENCY-1];
    assign out_tag    = tag[LATENCY-1];

endmodule

// File: rtl/falu_issue_ctrl.sv
// Round-robin issue controller for the shared FAlu with FCSR0 serialisation
// (drain before issue, retire before anything else issues).
module falu_issue_ctrl
    import falu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH_FALU = 32,
    parameter int LATENCY    = FALU_LATENCY,
    parameter int TAG_W      = 6
) (
    input  logic                  Clk,
    input  logic                  Rest,
    input  logic                  ReqValid0,
    input  logic                  ReqValid1,
    input  logic                  ReqSerial0,
    input  logic                  ReqSerial1,
    input  logic [MIC_OP_W-1:0]   ReqOp0,
    input  logic [MIC_OP_W-1:0]   ReqOp1,
    input  logic [TAG_W-1:0]      ReqTag0,
    input  logic [TAG_W-1:0]      ReqTag1,
    input  logic [ARCH_REG_W-1:0] ReqRd0,
    input  logic [ARCH_REG_W-1:0] ReqRd1,
    output logic                  ReqReady0,
    output logic                  ReqReady1,
    input  logic                  Flush,
    output logic                  FaluValid,
    output logic [MIC_OP_W-1:0]   FaluOp,
    output logic [ARCH_REG_W-1:0] FaluRd,
    output logic                  WbValid,
    output logic [TAG_W-1:0]      WbTag,
    output logic                  Busy
);

    generate
        if (LATENCY < 1 || LATENCY > 8 || WIDTH_FALU < 1) begin : g_bad_param
            $error("falu_issue_ctrl: LATENCY must be 1..8");
        end
    endgenerate

    logic [1:0] state, state_nxt;
    logic       last_gnt, ser_lane;
    logic       gnt0, gnt1, accept;
    logic       win, win_valid, win_serial;
    logic       pipe_any, pipe_empty;
    logic       wb_raw, wb_serial;

    assign win        = (ReqValid0 & ReqValid1) ? ~last_gnt : ReqValid1;
    assign win_valid  = ReqValid0 | ReqValid1;
    assign win_serial = win ? ReqSerial1 : ReqSerial0;
    assign pipe_empty = ~pipe_any & ~FaluValid;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        case (state)
            FIC_IDLE: begin
                if (win_valid) begin
                    if (!win_serial || pipe_empty) begin
                        gnt0 = ~win;
                        gnt1 = win;
                        if (win_serial) state_nxt = FIC_SERIAL;
                    end else begin
                        state_nxt = FIC_DRAIN;
                    end
                end
            end
            FIC_DRAIN: begin
                if (pipe_empty) begin
                    if (ser_lane ? ReqValid1 : ReqValid0) begin
                        gnt0      = ~ser_lane;
                        gnt1      = ser_lane;
                        state_nxt = FIC_SERIAL;
                    end else begin
                        state_nxt = FIC_IDLE;
                    end
                end
            end
            FIC_SERIAL: begin
                if (wb_raw && wb_serial) state_nxt = FIC_IDLE;
            end
            default: state_nxt = FIC_IDLE;
        endcase
        if (Flush) begin
            gnt0      = 1'b0;
            gnt1      = 1'b0;
            state_nxt = FIC_IDLE;
        end
    end

    assign accept    = gnt0 | gnt1;
    assign ReqReady0 = gnt0 & Rest;
    assign ReqReady1 = gnt1 & Rest;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state     <= FIC_IDLE;
            last_gnt  <= 1'b1;
            ser_lane  <= 1'b0;
            FaluValid <= 1'b0;
            FaluOp    <= '0;
            FaluRd    <= '0;
        end else begin
            state     <= state_nxt;
            FaluValid <= accept;
            if (accept) begin
                last_gnt <= gnt1;
                FaluOp   <= gnt1 ? ReqOp1 : ReqOp0;
                FaluRd   <= gnt1 ? ReqRd1 : ReqRd0;
            end
            if (state == FIC_IDLE && state_nxt == FIC_DRAIN) ser_lane <= win;
        end
    end

    falu_shadow_pipe #(
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) u_pipe (
        .clk        (Clk),
        .rst_n      (Rest),
        .flush      (Flush),
        .ld_valid   (accept),
        .ld_serial  (gnt1 ? ReqSerial1 : ReqSerial0),
        .ld_tag     (gnt1 ? ReqTag1 : ReqTag0),
        .any_valid  (pipe_any),
        .out_valid  (wb_raw),
        .out_serial (wb_serial),
        .out_tag    (WbTag)
    );

    // A flushed result must not retire even if it reaches the last stage this cycle.
    assign WbValid = wb_raw & ~Flush;
    assign Busy    = (state != FIC_IDLE) | pipe_any | FaluValid;

endmodule

// File: tb/tb_falu_issue_ctrl.sv
// Directed, table-driven bench for falu_issue_ctrl (LATENCY=3) with hand-written
// reset sequences.
module tb_falu_issue_ctrl;
    import falu_issue_ctrl_pkg::*;

    logic                  Clk = 1'b0;
    logic                  Rest = 1'b0;
    logic                  ReqValid0, ReqValid1, ReqSerial0, ReqSerial1;
    logic [MIC_OP_W-1:0]   ReqOp0, ReqOp1;
    logic [5:0]            ReqTag0, ReqTag1;
    logic [ARCH_REG_W-1:0] ReqRd0, ReqRd1;
    logic                  ReqReady0, ReqReady1, Flush;
    logic                  FaluValid, WbValid, Busy;
    logic [MIC_OP_W-1:0]   FaluOp;
    logic [ARCH_REG_W-1:0] FaluRd;
    logic [5:0]            WbTag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v0, s0;
        logic [5:0] t0;
        logic       v1, s1;
        logic [5:0] t1;
        logic       fl;
        logic       r0, r1, fv;
        logic [5:0] fop;
        logic       wb;
        logic [5:0] wt;
        logic       bz;
    } vec_t;

    vec_t tbl[$];

    falu_issue_ctrl #(
        .WIDTH_FALU (32),
        .LATENCY    (3),
        .TAG_W      (6)
    ) dut (
        .Clk        (Clk),
        .Rest       (Rest),
        .ReqValid0  (ReqValid0),
        .ReqValid1  (ReqValid1),
        .ReqSerial0 (ReqSerial0),
        .ReqSerial1 (ReqSerial1),
        .ReqOp0     (ReqOp0),
        .ReqOp1     (ReqOp1),
        .ReqTag0    (ReqTag0),
        .ReqTag1    (ReqTag1),
        .ReqRd0     (ReqRd0),
        .ReqRd1     (ReqRd1),
        .ReqReady0  (ReqReady0),
        .ReqReady1  (ReqReady1),
        .Flush      (Flush),
        .FaluValid  (FaluValid),
        .FaluOp     (FaluOp),
        .FaluRd     (FaluRd),
        .WbValid    (WbValid),
        .WbTag      (WbTag),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic add(input logic v0, s0, input logic [5:0] t0,
                       input logic v1, s1, input logic [5:0] t1, input logic fl,
                       input logic r0, r1, fv, input logic [5:0] fop,
                       input logic wb, input logic [5:0] wt, input logic bz);
        vec_t v;
        v.v0 = v0; v.s0 = s0; v.t0 = t0; v.v1 = v1; v.s1 = s1; v.t1 = t1; v.fl = fl;
        v.r0 = r0; v.r1 = r1; v.fv = fv; v.fop = fop; v.wb = wb; v.wt = wt; v.bz = bz;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic v0, s0, input logic [5:0] t0,
                         input logic v1, s1, input logic [5:0] t1, input logic fl);
        ReqValid0 = v0; ReqSerial0 = s0; ReqTag0 = t0;
        ReqOp0 = MIC_OP_W'(t0); ReqRd0 = ARCH_REG_W'(t0);
        ReqValid1 = v1; ReqSerial1 = s1; ReqTag1 = t1;
        ReqOp1 = MIC_OP_W'(t1); ReqRd1 = ARCH_REG_W'(t1);
        Flush = fl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input int i, input vec_t e);
        chk($sformatf("row%0d ReqReady0", i), 32'(ReqReady0), 32'(e.r0));
        chk($sformatf("row%0d ReqReady1", i), 32'(ReqReady1), 32'(e.r1));
        chk($sformatf("row%0d FaluValid", i), 32'(FaluValid), 32'(e.fv));
        chk($sformatf("row%0d WbValid", i), 32'(WbValid), 32'(e.wb));
        chk($sformatf("row%0d Busy", i), 32'(Busy), 32'(e.bz));
        if (e.fv) begin
            chk($sformatf("row%0d FaluOp", i), 32'(FaluOp), 32'(e.fop));
            chk($sformatf("row%0d FaluRd", i), 32'(FaluRd), 32'(ARCH_REG_W'(e.fop)));
        end
        if (e.wb) chk($sformatf("row%0d WbTag", i), 32'(WbTag), 32'(e.wt));
    endtask

    initial begin
        // v0 s0 t0  v1 s1 t1  fl | r0 r1 fv fop  wb wt  busy
        // round-robin, both lanes valid
        add(1,0,6'h01, 1,0,6'h11, 0,  1,0,0,6'h00, 0,6'h00, 0);
        add(1,0,6'h01, 1,0,6'h11, 0,  0,1,1,6'h01, 0,6'h00, 1);
        add(1,0,6'h01, 1,0,6'h11, 0,  1,0,1,6'h11, 0,6'h00, 1);
        add(1,0,6'h01, 1,0,6'h11, 0,  0,1,1,6'h01, 1,6'h01, 1);
        add(1,0,6'h01, 1,0,6'h11, 0,  1,0,1,6'h11, 1,6'h11, 1);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,1,6'h01, 1,6'h01, 1);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,0,6'h00, 1,6'h11, 1);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,0,6'h00, 1,6'h01, 1);
        // serial behind two in-flight ops: DRAIN for two cycles
        add(1,0,6'h02, 0,0,6'h00, 0,  1,0,0,6'h00, 0,6'h00, 0);
        add(0,0,6'h00, 1,0,6'h03, 0,  0,1,1,6'h02, 0,6'h00, 1);
        add(1,1,6'h04, 0,0,6'h00, 0,  0,0,1,6'h03, 0,6'h00, 1);
        add(1,1,6'h04, 0,0,6'h00, 0,  0,0,0,6'h00, 1,6'h02, 1);
        add(1,1,6'h04, 0,0,6'h00, 0,  0,0,0,6'h00, 1,6'h03, 1);
        add(1,1,6'h04, 0,0,6'h00, 0,  1,0,0,6'h00, 0,6'h00, 1);
        add(0,0,6'h00, 1,0,6'h05, 0,  0,0,1,6'h04, 0,6'h00, 1);
        add(0,0,6'h00, 1,0,6'h05, 0,  0,0,0,6'h00, 0,6'h00, 1);
        add(0,0,6'h00, 1,0,6'h05, 0,  0,0,0,6'h00, 1,6'h04, 1);
        add(0,0,6'h00, 1,0,6'h05, 0,  0,1,0,6'h00, 0,6'h00, 0);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,1,6'h05, 0,6'h00, 1);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,0,6'h00, 0,6'h00, 1);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,0,6'h00, 1,6'h05, 1);
        // serial on empty pipe, lane 1
        add(0,0,6'h00, 1,1,6'h09, 0,  0,1,0,6'h00, 0,6'h00, 0);
        add(1,0,6'h06, 0,0,6'h00, 0,  0,0,1,6'h09, 0,6'h00, 1);
        add(1,0,6'h06, 0,0,6'h00, 0,  0,0,0,6'h00, 0,6'h00, 1);
        add(1,0,6'h06, 0,0,6'h00, 0,  0,0,0,6'h00, 1,6'h09, 1);
        add(1,0,6'h06, 0,0,6'h00, 0,  1,0,0,6'h00, 0,6'h00, 0);
        // three ops in flight then flush with lane 0 waiting
        add(1,0,6'h07, 0,0,6'h00, 0,  1,0,1,6'h06, 0,6'h00, 1);
        add(0,0,6'h00, 1,0,6'h08, 0,  0,1,1,6'h07, 0,6'h00, 1);
        add(1,0,6'h0A, 0,0,6'h00, 0,  1,0,1,6'h08, 1,6'h06, 1);
        add(1,0,6'h0B, 0,0,6'h00, 1,  0,0,1,6'h0A, 0,6'h00, 1);
        add(1,0,6'h0B, 0,0,6'h00, 0,  1,0,0,6'h00, 0,6'h00, 0);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,1,6'h0B, 0,6'h00, 1);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,0,6'h00, 0,6'h00, 1);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,0,6'h00, 1,6'h0B, 1);
        add(0,0,6'h00, 0,0,6'h00, 0,  0,0,0,6'h00, 0,6'h00, 0);

        // reset held with both lanes requesting
        drive(1,0,6'h01, 1,0,6'h11, 0);
        Rest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk($sformatf("reset%0d ReqReady0", k), 32'(ReqReady0), 32'd0);
            chk($sformatf("reset%0d ReqReady1", k), 32'(ReqReady1), 32'd0);
            chk($sformatf("reset%0d FaluValid", k), 32'(FaluValid), 32'd0);
            chk($sformatf("reset%0d WbValid", k), 32'(WbValid), 32'd0);
            chk($sformatf("reset%0d Busy", k), 32'(Busy), 32'd0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge Clk);
            #1;
            if (i == 0) Rest = 1'b1;
            drive(tbl[i].v0, tbl[i].s0, tbl[i].t0, tbl[i].v1, tbl[i].s1, tbl[i].t1, tbl[i].fl);
            @(negedge Clk);
            check_row(i, tbl[i]);
        end

        // asynchronous reset while a serial op is in flight
        @(posedge Clk); #1;
        drive(0,0,6'h00, 1,1,6'h12, 0);
        @(negedge Clk);
        chk("midrst accept ReqReady1", 32'(ReqReady1), 32'd1);
        @(posedge Clk); #1;
        drive(1,0,6'h13, 0,0,6'h00, 0);
        @(negedge Clk);
        chk("midrst serial FaluValid", 32'(FaluValid), 32'd1);
        chk("midrst serial ReqReady0", 32'(ReqReady0), 32'd0);
        #2 Rest = 1'b0;
        #1;
        chk("midrst async FaluValid", 32'(FaluValid), 32'd0);
        chk("midrst async FaluOp", 32'(FaluOp), 32'd0);
        chk("midrst async WbValid", 32'(WbValid), 32'd0);
        chk("midrst async Busy", 32'(Busy), 32'd0);
        chk("midrst async ReqReady0", 32'(ReqReady0), 32'd0);
        @(posedge Clk); #1;
        Rest = 1'b1;
        @(negedge Clk);
        chk("midrst release ReqReady0", 32'(ReqReady0), 32'd1);
        chk("midrst release Busy", 32'(Busy), 32'd0);
        @(posedge Clk); #1;
        drive(0,0,6'h00, 0,0,6'h00, 0);
        @(negedge Clk);
        chk("midrst c1 FaluValid", 32'(FaluValid), 32'd1);
        chk("midrst c1 FaluOp", 32'(FaluOp), 32'h13);
        chk("midrst c1 WbValid", 32'(WbValid), 32'd0);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("midrst c2 WbValid", 32'(WbValid), 32'd0);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("midrst c3 WbValid", 32'(WbValid), 32'd1);
        chk("midrst c3 WbTag", 32'(WbTag), 32'h13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
